// File: rtl/iterative_left_shifter.sv
// Iterative 8-bit left shifter: LSL, ROL and ASL, one bit per clock.
// Results and flags are published only on the completion edge, together with a one-cycle DONE pulse.
module iterative_left_shifter (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [1:0] OPCODE,
  input  logic [7:0] DATA,
  input  logic [7:0] SHIFT_AMOUNT,
  output logic [7:0] RESULT,
  output logic       BUSY,
  output logic       DONE,
  output logic       CARRY,
  output logic       OVERFLOW
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_ROL = 2'b01;
  localparam logic [1:0] OP_ASL = 2'b10;

  state_t      state_q, state_d;
  logic [7:0]  work_q, work_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        carry_q, carry_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  result_q, result_d;
  logic        carry_out_q, carry_out_d;
  logic        ovf_out_q, ovf_out_d;
  logic        done_q, done_d;
  logic [3:0]  cnt_load;

  // A full 8-bit rotation is the identity, so ROL only needs the low three bits.
  always_comb begin
    cnt_load = 4'd0;
    case (OPCODE)
      OP_LSL, OP_ASL: cnt_load = (SHIFT_AMOUNT >= 8'd8) ? 4'd8 : SHIFT_AMOUNT[3:0];
      OP_ROL:         cnt_load = {1'b0, SHIFT_AMOUNT[2:0]};
      default:        cnt_load = 4'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    ovf_out_d   = ovf_out_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          work_d  = DATA;
          op_d    = OPCODE;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = cnt_load;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          case (op_q)
            OP_LSL: begin
              carry_d = work_q[7];
              work_d  = {work_q[6:0], 1'b0};
            end
            OP_ROL: begin
              carry_d = work_q[7];
              work_d  = {work_q[6:0], work_q[7]};
            end
            OP_ASL: begin
              carry_d = work_q[7];
              work_d  = {work_q[6:0], 1'b0};
              ovf_d   = ovf_q | (work_q[7] ^ work_q[6]);
            end
            default: begin
              work_d = work_q;
            end
          endcase
        end else begin
          result_d    = work_q;
          carry_out_d = carry_q;
          ovf_out_d   = ovf_q;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      work_q      <= 8'h00;
      cnt_q       <= 4'd0;
      op_q        <= 2'b00;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      result_q    <= 8'h00;
      carry_out_q <= 1'b0;
      ovf_out_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      ovf_out_q   <= ovf_out_d;
      done_q      <= done_d;
    end
  end

  assign RESULT   = result_q;
  assign CARRY    = carry_out_q;
  assign OVERFLOW = ovf_out_q;
  assign DONE     = done_q;
  assign BUSY     = (state_q == SHIFT);

endmodule

// File: tb/tb_iterative_left_shifter.sv
// Directed bench for iterative_left_shifter: hand-computed vectors, latency, hold, busy-ignore and reset abort.
module tb_iterative_left_shifter;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [1:0] OPCODE;
  logic [7:0] DATA;
  logic [7:0] SHIFT_AMOUNT;
  logic [7:0] RESULT;
  logic       BUSY;
  logic       DONE;
  logic       CARRY;
  logic       OVERFLOW;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] op;
    logic [7:0] d;
    logic [7:0] sa;
    logic [7:0] r;
    logic       c;
    logic       o;
    int         lat;
    string      name;
  } vec_t;

  iterative_left_shifter dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OPCODE(OPCODE), .DATA(DATA),
    .SHIFT_AMOUNT(SHIFT_AMOUNT), .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE),
    .CARRY(CARRY), .OVERFLOW(OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Called at a sample point (#1 after a rising edge). Returns with the bench at the DONE sample point.
  task automatic do_op(input logic [1:0] op, input logic [7:0] d, input logic [7:0] sa,
                       output int lat, output logic [7:0] res, output logic c, output logic o,
                       output logic busy0, output logic held, output logic busy_done);
    logic [7:0] prev;
    START = 1'b1; OPCODE = op; DATA = d; SHIFT_AMOUNT = sa;
    @(posedge CLK); #1;
    START = 1'b0; OPCODE = op ^ 2'b01; DATA = ~d; SHIFT_AMOUNT = 8'd3;
    busy0 = BUSY;
    prev = RESULT;
    held = 1'b1;
    lat = 0;
    while (lat < 30) begin
      @(posedge CLK); #1;
      lat++;
      if (DONE) break;
      if (RESULT !== prev || BUSY !== 1'b1) held = 1'b0;
    end
    res = RESULT; c = CARRY; o = OVERFLOW; busy_done = BUSY;
  endtask

  task automatic test_reset;
    RESET = 1'b1; START = 1'b1; OPCODE = 2'b00; DATA = 8'hA5; SHIFT_AMOUNT = 8'd1;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++;
    if ({RESULT, BUSY, DONE, CARRY, OVERFLOW} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs got res=%h busy=%b done=%b c=%b o=%b exp 00/0/0/0/0",
               RESULT, BUSY, DONE, CARRY, OVERFLOW);
    end
    RESET = 1'b0;
    START = 1'b0;
  endtask

  task automatic test_vectors;
    vec_t v[$];
    int lat;
    logic [7:0] res;
    logic c, o, b0, held, bd;
    v.push_back('{2'b00, 8'h81, 8'd1,   8'h02, 1'b1, 1'b0, 2, "lsl_81_1"});
    v.push_back('{2'b01, 8'h81, 8'd1,   8'h03, 1'b1, 1'b0, 2, "rol_81_1"});
    v.push_back('{2'b01, 8'h96, 8'd8,   8'h96, 1'b0, 1'b0, 1, "rol_96_8"});
    v.push_back('{2'b01, 8'h96, 8'd11,  8'hB4, 1'b0, 1'b0, 4, "rol_96_11"});
    v.push_back('{2'b00, 8'hFF, 8'd8,   8'h00, 1'b1, 1'b0, 9, "lsl_ff_8"});
    v.push_back('{2'b00, 8'hFF, 8'd200, 8'h00, 1'b1, 1'b0, 9, "lsl_ff_200"});
    v.push_back('{2'b10, 8'h40, 8'd1,   8'h80, 1'b0, 1'b1, 2, "asl_40_1"});
    v.push_back('{2'b10, 8'hC0, 8'd1,   8'h80, 1'b1, 1'b0, 2, "asl_c0_1"});
    v.push_back('{2'b10, 8'h70, 8'd3,   8'h80, 1'b1, 1'b1, 4, "asl_70_3_sticky"});
    v.push_back('{2'b00, 8'h40, 8'd1,   8'h80, 1'b0, 1'b0, 2, "lsl_40_no_ovf"});
    v.push_back('{2'b10, 8'hC0, 8'd0,   8'hC0, 1'b0, 1'b0, 1, "asl_zero_cnt"});
    v.push_back('{2'b00, 8'h5A, 8'd0,   8'h5A, 1'b0, 1'b0, 1, "lsl_5a_0"});
    v.push_back('{2'b00, 8'h81, 8'd1,   8'h02, 1'b1, 1'b0, 2, "lsl_81_again"});
    v.push_back('{2'b11, 8'h3C, 8'd5,   8'h3C, 1'b0, 1'b0, 1, "op11_3c"});
    v.push_back('{2'b01, 8'h0F, 8'd4,   8'hF0, 1'b0, 1'b0, 5, "rol_0f_4"});
    // Vectors run back to back: each START is raised during the previous DONE cycle.
    foreach (v[i]) begin
      do_op(v[i].op, v[i].d, v[i].sa, lat, res, c, o, b0, held, bd);
      n_cmp++;
      if (res !== v[i].r || c !== v[i].c || o !== v[i].o) begin
        n_bad++;
        $display("FAIL %s result got %h/c%b/o%b exp %h/c%b/o%b",
                 v[i].name, res, c, o, v[i].r, v[i].c, v[i].o);
      end
      n_cmp++;
      if (lat !== v[i].lat) begin
        n_bad++;
        $display("FAIL %s latency got %0d exp %0d", v[i].name, lat, v[i].lat);
      end
      n_cmp++;
      if (b0 !== 1'b1 || held !== 1'b1 || bd !== 1'b0) begin
        n_bad++;
        $display("FAIL %s busy/hold got busy0=%b held=%b busy_at_done=%b exp 1/1/0",
                 v[i].name, b0, held, bd);
      end
    end
  endtask

  task automatic test_done_pulse;
    int lat;
    logic [7:0] res;
    logic c, o, b0, held, bd;
    do_op(2'b00, 8'h03, 8'd2, lat, res, c, o, b0, held, bd);
    n_cmp++;
    if (res !== 8'h0C || lat !== 3) begin
      n_bad++;
      $display("FAIL pulse_op got %h lat %0d exp 0c lat 3", res, lat);
    end
    @(posedge CLK); #1;
    n_cmp++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || RESULT !== 8'h0C) begin
      n_bad++;
      $display("FAIL done_single_cycle got done=%b busy=%b res=%h exp 0/0/0c", DONE, BUSY, RESULT);
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    START = 1'b1; OPCODE = 2'b00; DATA = 8'h01; SHIFT_AMOUNT = 8'd5;
    @(posedge CLK); #1;          // E0
    START = 1'b0;
    @(posedge CLK); #1;          // E0+1
    START = 1'b1; OPCODE = 2'b01; DATA = 8'hFF; SHIFT_AMOUNT = 8'd2;
    @(posedge CLK); #1;          // E0+2: START sampled while busy
    START = 1'b0;
    lat = 2;
    while (lat < 30) begin
      @(posedge CLK); #1;
      lat++;
      if (DONE) break;
    end
    n_cmp++;
    if (lat !== 6 || RESULT !== 8'h20 || CARRY !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_ignore got res=%h c=%b lat=%0d exp 20/0/6", RESULT, CARRY, lat);
    end
    @(posedge CLK); #1;
    n_cmp++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_ignore_no_restart got busy=%b done=%b exp 0/0", BUSY, DONE);
    end
  endtask

  task automatic test_reset_abort;
    logic saw_done;
    int lat;
    logic [7:0] res;
    logic c, o, b0, held, bd;
    START = 1'b1; OPCODE = 2'b00; DATA = 8'h01; SHIFT_AMOUNT = 8'd5;
    @(posedge CLK); #1;          // E0
    START = 1'b0;
    repeat (2) @(posedge CLK);
    #1;                          // E0+2
    RESET = 1'b1; START = 1'b1; DATA = 8'h77;
    @(posedge CLK); #1;          // E0+3: reset wins over START
    RESET = 1'b0; START = 1'b0;
    n_cmp++;
    if ({RESULT, BUSY, DONE, CARRY, OVERFLOW} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_abort_outputs got res=%h busy=%b done=%b c=%b o=%b exp 00/0/0/0/0",
               RESULT, BUSY, DONE, CARRY, OVERFLOW);
    end
    saw_done = 1'b0;
    repeat (8) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_abort_no_done got activity=%b exp 0", saw_done);
    end
    do_op(2'b01, 8'h81, 8'd1, lat, res, c, o, b0, held, bd);
    n_cmp++;
    if (res !== 8'h03 || c !== 1'b1 || lat !== 2) begin
      n_bad++;
      $display("FAIL after_reset_op got %h c%b lat %0d exp 03 c1 lat 2", res, c, lat);
    end
  endtask

  task automatic test_first_after_reset;
    int lat;
    logic [7:0] res;
    logic c, o, b0, held, bd;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    do_op(2'b10, 8'h40, 8'd1, lat, res, c, o, b0, held, bd);
    n_cmp++;
    if (res !== 8'h80 || o !== 1'b1 || c !== 1'b0 || lat !== 2) begin
      n_bad++;
      $display("FAIL first_edge_start got %h c%b o%b lat %0d exp 80 c0 o1 lat 2", res, c, o, lat);
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_done_pulse;
    test_busy_ignore;
    test_reset_abort;
    test_first_after_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
